// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcode encodings and fetch state type for the 8-bit CPU
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  // Instruction format: {opcode[7:5], reg[4:3], field[2:0]}
  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_BRZ  = 3'b110;
  localparam logic [2:0] OP_JUMP = 3'b111;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HOLD
  } fetch_state_e;

  function automatic logic [2:0] instr_opcode(input logic [7:0] ins);
    return ins[7:5];
  endfunction

endpackage

// File: rtl/instr_prefetch_buf.sv
// rtl/instr_prefetch_buf.sv - one-entry instruction holding register with flush
module instr_prefetch_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and instruction fetch initiator; INSTR_FETCH_PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e      state;
  logic              drop;
  logic              handshake;
  logic [ADDR_W-1:0] pc_inc;

  assign handshake = instr_valid && instr_ready;
  assign pc_inc    = pc + 1'b1;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic               pf_pending;
  logic               pf_valid;
  logic [INSTR_W-1:0] pf_data;
  logic               pf_load;
  logic               pf_take;

  assign pf_load = (state == FS_HOLD) && pf_pending && imem_rvalid && !jump_valid && !handshake;
  assign pf_take = (state == FS_HOLD) && handshake && pf_valid && !jump_valid;

  instr_prefetch_buf #(.W(INSTR_W)) u_pf_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jump_valid),
    .load      (pf_load),
    .take      (pf_take),
    .load_data (imem_rdata),
    .valid     (pf_valid),
    .data      (pf_data)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      drop        <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_pending  <= 1'b0;
`endif
    end else begin
      imem_req <= 1'b0;
      case (state)
        FS_IDLE: begin
          if (jump_valid) pc <= jump_target;
          if (fetch_en) begin
            state     <= FS_REQ;
            imem_req  <= 1'b1;
            imem_addr <= jump_valid ? jump_target : pc;
          end
        end
        // The request already on the bus used the old pc; its data must be dropped.
        FS_REQ: begin
          state <= FS_WAIT;
          if (jump_valid) begin
            pc   <= jump_target;
            drop <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (imem_rvalid && (drop || jump_valid)) begin
            drop      <= 1'b0;
            state     <= FS_REQ;
            imem_req  <= 1'b1;
            imem_addr <= jump_valid ? jump_target : pc;
            if (jump_valid) pc <= jump_target;
          end else if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            state       <= FS_HOLD;
`ifdef INSTR_FETCH_PREFETCH_EN
            if (fetch_en) begin
              imem_req   <= 1'b1;
              imem_addr  <= pc_inc;
              pf_pending <= 1'b1;
            end
`endif
          end else if (jump_valid) begin
            pc   <= jump_target;
            drop <= 1'b1;
          end
        end
        FS_HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (jump_valid) begin
            pc          <= jump_target;
            instr_valid <= 1'b0;
            pf_pending  <= 1'b0;
            // An outstanding prefetch is drained through WAIT so its response is discarded.
            if (pf_pending && !imem_rvalid) begin
              state <= FS_WAIT;
              drop  <= 1'b1;
            end else begin
              state     <= FS_REQ;
              imem_req  <= 1'b1;
              imem_addr <= jump_target;
            end
          end else if (handshake) begin
            if (pf_valid) begin
              instr <= pf_data;
              if (fetch_en) begin
                imem_req   <= 1'b1;
                imem_addr  <= pc;
                pf_pending <= 1'b1;
              end
            end else if (pf_pending && imem_rvalid) begin
              instr      <= imem_rdata;
              pc         <= pc_inc;
              pf_pending <= 1'b0;
              if (fetch_en) begin
                imem_req   <= 1'b1;
                imem_addr  <= pc_inc;
                pf_pending <= 1'b1;
              end
            end else if (pf_pending) begin
              instr_valid <= 1'b0;
              pf_pending  <= 1'b0;
              state       <= FS_WAIT;
            end else begin
              instr_valid <= 1'b0;
              if (fetch_en) begin
                state     <= FS_REQ;
                imem_req  <= 1'b1;
                imem_addr <= pc;
              end else begin
                state <= FS_IDLE;
              end
            end
          end else if (pf_pending && imem_rvalid) begin
            pc         <= pc_inc;
            pf_pending <= 1'b0;
          end else if (!pf_pending && !pf_valid && fetch_en) begin
            imem_req   <= 1'b1;
            imem_addr  <= pc;
            pf_pending <= 1'b1;
          end
`else
          if (jump_valid) begin
            pc          <= jump_target;
            instr_valid <= 1'b0;
            state       <= FS_REQ;
            imem_req    <= 1'b1;
            imem_addr   <= jump_target;
          end else if (handshake) begin
            instr_valid <= 1'b0;
            if (fetch_en) begin
              state     <= FS_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              state <= FS_IDLE;
            end
          end
`endif
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch (default build)
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_rvalid;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic [7:0] pc;

  logic [7:0] mem [256];
  logic       mem_en;
  logic       rsp_v;
  logic [7:0] rsp_d;
  logic       force_rv;
  logic [7:0] force_d;

  logic [7:0] addr_log [$];
  logic [7:0] acc_log [$];
  int         vcycles = 0;

  int errors = 0;
  int checks = 0;
  int a0, c0, v0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .pc          (pc)
  );

  // One-cycle-latency instruction memory, plus a manual response override.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v <= 1'b0;
      rsp_d <= 8'h00;
    end else begin
      rsp_v <= mem_en && imem_req;
      rsp_d <= mem[imem_addr];
    end
  end

  assign imem_rvalid = rsp_v | force_rv;
  assign imem_rdata  = force_rv ? force_d : rsp_d;

  always @(negedge clk) begin
    if (imem_req) addr_log.push_back(imem_addr);
    if (instr_valid && instr_ready) acc_log.push_back(instr);
    if (instr_valid) vcycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input int n, input string tag);
    for (int i = 0; i < 60 && addr_log.size() < n; i++) step();
    check_eq(tag, addr_log.size(), n);
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 60 && acc_log.size() < n; i++) step();
    check_eq(tag, acc_log.size(), n);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !instr_valid; i++) step();
    check_eq(tag, instr_valid, 1);
  endtask

  task automatic mark();
    a0 = addr_log.size();
    c0 = acc_log.size();
    v0 = vcycles;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h21; mem[8'h01] = 8'h42; mem[8'h02] = 8'h63; mem[8'h03] = 8'h5A;
    mem[8'hFF] = 8'h77; mem[8'h10] = 8'h99; mem[8'h40] = 8'h3C;
    mem[8'h41] = 8'h55; mem[8'h80] = 8'h66;
    rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0;
    jump_target = 8'h00; mem_en = 1'b1; force_rv = 1'b0; force_d = 8'h00;
    step(); step();
    check_eq("rst pc", pc, 8'h00);
    check_eq("rst imem_req", imem_req, 0);
    check_eq("rst imem_addr", imem_addr, 8'h00);
    check_eq("rst instr", instr, 8'h00);
    check_eq("rst instr_valid", instr_valid, 0);
    rst_n = 1'b1;
    step();

    // Three back-to-back fetches with the decoder always ready.
    mark();
    instr_ready = 1'b1; fetch_en = 1'b1;
    wait_addr(a0 + 3, "seq req count");
    fetch_en = 1'b0;
    wait_acc(c0 + 3, "seq accept count");
    step(); step();
    check_eq("seq addr0", addr_log[a0], 8'h00);
    check_eq("seq addr1", addr_log[a0+1], 8'h01);
    check_eq("seq addr2", addr_log[a0+2], 8'h02);
    check_eq("seq instr0", acc_log[c0], 8'h21);
    check_eq("seq instr1", acc_log[c0+1], 8'h42);
    check_eq("seq instr2", acc_log[c0+2], 8'h63);
    check_eq("seq valid cycles", vcycles - v0, 3);
    check_eq("seq pc", pc, 8'h03);
    check_eq("seq idle valid", instr_valid, 0);

    // Decoder stalls: instruction must stay put and no new request may issue.
    mark();
    instr_ready = 1'b0; fetch_en = 1'b1;
    wait_valid("hold valid seen");
    a0 = addr_log.size();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold instr", instr, 8'h5A);
      check_eq("hold valid", instr_valid, 1);
      step();
    end
    check_eq("hold no req", addr_log.size() - a0, 0);
    instr_ready = 1'b1; fetch_en = 1'b0;
    step(); step();
    check_eq("hold accept count", acc_log.size() - c0, 1);
    check_eq("hold accept instr", acc_log[c0], 8'h5A);
    check_eq("hold pc", pc, 8'h04);

    // PC wrap from 0xFF to 0x00.
    jump_valid = 1'b1; jump_target = 8'hFF;
    step();
    jump_valid = 1'b0;
    check_eq("idle jump pc", pc, 8'hFF);
    mark();
    fetch_en = 1'b1;
    wait_addr(a0 + 2, "wrap req count");
    fetch_en = 1'b0;
    wait_acc(c0 + 2, "wrap accept count");
    step(); step();
    check_eq("wrap addr0", addr_log[a0], 8'hFF);
    check_eq("wrap addr1", addr_log[a0+1], 8'h00);
    check_eq("wrap instr0", acc_log[c0], 8'h77);
    check_eq("wrap instr1", acc_log[c0+1], 8'h21);
    check_eq("wrap pc", pc, 8'h01);

    // Jump while waiting on the response for 0x10: that response is dropped.
    jump_valid = 1'b1; jump_target = 8'h10;
    step();
    jump_valid = 1'b0;
    mark();
    mem_en = 1'b0; fetch_en = 1'b1;
    step();
    check_eq("drop req", imem_req, 1);
    check_eq("drop req addr", imem_addr, 8'h10);
    step();
    jump_valid = 1'b1; jump_target = 8'h40;
    step();
    jump_valid = 1'b0;
    check_eq("drop pc", pc, 8'h40);
    force_rv = 1'b1; force_d = 8'h99; mem_en = 1'b1; fetch_en = 1'b0;
    step();
    force_rv = 1'b0;
    check_eq("redirect req", imem_req, 1);
    check_eq("redirect addr", imem_addr, 8'h40);
    wait_acc(c0 + 1, "drop accept count");
    step(); step();
    check_eq("drop only one accept", acc_log.size() - c0, 1);
    check_eq("drop instr", acc_log[c0], 8'h3C);
    check_eq("drop addr count", addr_log.size() - a0, 2);
    check_eq("drop pc after", pc, 8'h41);

    // Jump coincident with the handshake in HOLD.
    mark();
    instr_ready = 1'b0; fetch_en = 1'b1;
    wait_valid("hsj valid seen");
    instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 8'h80; fetch_en = 1'b0;
    step();
    jump_valid = 1'b0;
    check_eq("hsj req", imem_req, 1);
    check_eq("hsj req addr", imem_addr, 8'h80);
    wait_acc(c0 + 2, "hsj accept count");
    step(); step();
    check_eq("hsj instr0", acc_log[c0], 8'h55);
    check_eq("hsj instr1", acc_log[c0+1], 8'h66);
    check_eq("hsj accepts", acc_log.size() - c0, 2);
    check_eq("hsj pc", pc, 8'h81);

    // Reset in WAIT, then a stale response after release.
    mem_en = 1'b0; fetch_en = 1'b1;
    step();
    check_eq("rw req addr", imem_addr, 8'h81);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rw pc", pc, 8'h00);
    check_eq("rw imem_req", imem_req, 0);
    check_eq("rw imem_addr", imem_addr, 8'h00);
    check_eq("rw instr", instr, 8'h00);
    check_eq("rw instr_valid", instr_valid, 0);
    fetch_en = 1'b0;
    step();
    rst_n = 1'b1;
    mark();
    step();
    force_rv = 1'b1; force_d = 8'hEE;
    step();
    force_rv = 1'b0;
    step(); step(); step();
    check_eq("late rsp valid", instr_valid, 0);
    check_eq("late rsp instr", instr, 8'h00);
    check_eq("late rsp pc", pc, 8'h00);
    check_eq("late rsp no req", addr_log.size() - a0, 0);
    check_eq("late rsp no accept", acc_log.size() - c0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
